// File: rtl/ctrl_sequencer_if.sv
// Handshake bundle between ctrl_sequencer and the datapath/host.
// master = sequencer side, slave = datapath/host side.
interface ctrl_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             START;
    logic [3:0]       opcode;
    logic             fcode;
    logic             DONE;
    logic             dp_start;
    logic             pc_stall;
    logic             CTRL_branch_rel_nz;
    logic             CTRL_branch_rel_z;
    logic             CTRL_branch_abs;
    logic             CTRL_reg_write_en;
    logic             CTRL_reg_sel;
    logic             CTRL_lut_in;
    logic             CTRL_mem_to_reg;
    logic             CTRL_alu_src;
    logic             CTRL_alu_sc_in;
    logic             CTRL_read_mem;
    logic             CTRL_write_mem;
    logic [2:0]       CTRL_alu_op;
    logic             halted;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  START, opcode, fcode, DONE,
        output dp_start, pc_stall,
               CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs,
               CTRL_reg_write_en, CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg,
               CTRL_alu_src, CTRL_alu_sc_in, CTRL_read_mem, CTRL_write_mem,
               CTRL_alu_op, halted, retired, stall_cycles
    );

    modport slave (
        output START, opcode, fcode, DONE,
        input  dp_start, pc_stall,
               CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs,
               CTRL_reg_write_en, CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg,
               CTRL_alu_src, CTRL_alu_sc_in, CTRL_read_mem, CTRL_write_mem,
               CTRL_alu_op, halted, retired, stall_cycles
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: opcode decode, init pulse, LW stall, halt.
// Define CTRL_PERF_CNT_EN to build the retired/stall_cycles counters.
module ctrl_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               reset_n,
    ctrl_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_LOAD2 = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_BZ   = 4'b1010;
    localparam logic [3:0] OP_BNZ  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_CMP  = 4'b1101;
    localparam logic [3:0] OP_LINK = 4'b1110;
    localparam logic [3:0] OP_SYS  = 4'b1111;

    state_t state_q, state_d;
    logic   decode_en;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // START outranks DONE, so a simultaneous DONE does not blank the decode.
    assign decode_en = bus.START || !bus.DONE;

    always_comb begin
        state_d                = state_q;
        bus.dp_start           = 1'b0;
        bus.pc_stall           = 1'b1;
        bus.halted             = 1'b0;
        bus.CTRL_branch_rel_nz = 1'b0;
        bus.CTRL_branch_rel_z  = 1'b0;
        bus.CTRL_branch_abs    = 1'b0;
        bus.CTRL_reg_write_en  = 1'b0;
        bus.CTRL_reg_sel       = 1'b0;
        bus.CTRL_lut_in        = 1'b0;
        bus.CTRL_mem_to_reg    = 1'b0;
        bus.CTRL_alu_src       = 1'b0;
        bus.CTRL_alu_sc_in     = 1'b0;
        bus.CTRL_read_mem      = 1'b0;
        bus.CTRL_write_mem     = 1'b0;
        bus.CTRL_alu_op        = 3'b000;

        case (state_q)
            S_IDLE: begin
                if (bus.START) state_d = S_INIT;
            end
            S_INIT: begin
                bus.dp_start = 1'b1;
                state_d      = S_RUN;
            end
            S_RUN: begin
                if (bus.START)                            state_d = S_INIT;
                else if (bus.DONE)                        state_d = S_HALT;
                else if (bus.opcode == OP_LW)             state_d = S_LOAD2;
                else if (bus.opcode == OP_SYS && bus.fcode) state_d = S_HALT;

                if (decode_en) begin
                    bus.pc_stall = 1'b0;
                    case (bus.opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            bus.CTRL_alu_op       = bus.opcode[2:0];
                            bus.CTRL_reg_write_en = 1'b1;
                        end
                        OP_SHL, OP_SHR: begin
                            bus.CTRL_alu_op       = bus.opcode[2:0];
                            bus.CTRL_alu_sc_in    = bus.fcode;
                            bus.CTRL_reg_write_en = 1'b1;
                        end
                        OP_ADDI: begin
                            bus.CTRL_alu_src      = 1'b1;
                            bus.CTRL_reg_write_en = 1'b1;
                        end
                        OP_LW: begin
                            bus.CTRL_read_mem = 1'b1;
                            bus.pc_stall      = 1'b1;
                        end
                        OP_SW:   bus.CTRL_write_mem     = 1'b1;
                        OP_BZ:   bus.CTRL_branch_rel_z  = 1'b1;
                        OP_BNZ:  bus.CTRL_branch_rel_nz = 1'b1;
                        OP_JMP: begin
                            bus.CTRL_branch_abs = 1'b1;
                            bus.CTRL_lut_in     = bus.fcode;
                        end
                        OP_CMP:  bus.CTRL_alu_op = 3'b001;
                        OP_LINK: begin
                            bus.CTRL_reg_sel      = 1'b1;
                            bus.CTRL_reg_write_en = 1'b1;
                        end
                        default: begin
                            // 1111: NOP when fcode=0, HALT (PC held) when fcode=1
                            bus.pc_stall = bus.fcode;
                        end
                    endcase
                end
            end
            S_LOAD2: begin
                if (bus.START)     state_d = S_INIT;
                else if (bus.DONE) state_d = S_HALT;
                else               state_d = S_RUN;

                if (decode_en) begin
                    bus.pc_stall          = 1'b0;
                    bus.CTRL_read_mem     = 1'b1;
                    bus.CTRL_mem_to_reg   = 1'b1;
                    bus.CTRL_reg_write_en = !bus.START;
                end
            end
            S_HALT: begin
                bus.halted = 1'b1;
                if (bus.START) state_d = S_INIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] retired_q, stall_q;
    logic             retire_inc, stall_inc;

    // Instructions aborted by START or cut off by DONE never complete.
    assign retire_inc = !bus.START && !bus.DONE &&
                        ((state_q == S_LOAD2) ||
                         (state_q == S_RUN && bus.opcode != OP_LW &&
                          !(bus.opcode == OP_SYS && bus.fcode)));
    assign stall_inc  = !bus.START && !bus.DONE &&
                        state_q == S_RUN && bus.opcode == OP_LW;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else if (state_q == S_INIT) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire_inc && retired_q != '1) retired_q <= retired_q + CNT_ONE;
            if (stall_inc && stall_q != '1)    stall_q   <= stall_q + CNT_ONE;
        end
    end

    assign bus.retired      = retired_q;
    assign bus.stall_cycles = stall_q;
`else
    assign bus.retired      = {CNT_W{1'b0}};
    assign bus.stall_cycles = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer; counter expectations
// follow whether CTRL_PERF_CNT_EN is defined for the build.
module tb_ctrl_sequencer;
    localparam int CNT_W = 8;
`ifdef CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Strobe packing: {nz,z,abs,we,sel,lut,m2r,src,sc,rd,wr,alu_op[2:0]}
    localparam logic [13:0] NZ  = 14'h2000;
    localparam logic [13:0] Z   = 14'h1000;
    localparam logic [13:0] ABS = 14'h0800;
    localparam logic [13:0] WE  = 14'h0400;
    localparam logic [13:0] SEL = 14'h0200;
    localparam logic [13:0] LUT = 14'h0100;
    localparam logic [13:0] M2R = 14'h0080;
    localparam logic [13:0] SRC = 14'h0040;
    localparam logic [13:0] SC  = 14'h0020;
    localparam logic [13:0] RD  = 14'h0010;
    localparam logic [13:0] WR  = 14'h0008;

    logic CLK = 1'b0;
    logic reset_n;
    int   n_total = 0;
    int   n_pass  = 0;
    int   exp_ret = 0;

    ctrl_sequencer_if #(.CNT_W(CNT_W)) bus ();

    ctrl_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    logic [13:0] strb;
    assign strb = {bus.CTRL_branch_rel_nz, bus.CTRL_branch_rel_z, bus.CTRL_branch_abs,
                   bus.CTRL_reg_write_en, bus.CTRL_reg_sel, bus.CTRL_lut_in,
                   bus.CTRL_mem_to_reg, bus.CTRL_alu_src, bus.CTRL_alu_sc_in,
                   bus.CTRL_read_mem, bus.CTRL_write_mem, bus.CTRL_alu_op};

    logic [3:0]  tbl_op [15] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9,
                                 4'hA, 4'hB, 4'hC, 4'hC, 4'hD, 4'hE, 4'hF};
    logic        tbl_fc [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [13:0] tbl_exp [15] = '{WE | 14'd1, WE | 14'd2, WE | 14'd3, WE | 14'd4,
                                  WE | SC | 14'd5, WE | 14'd6, WE | SRC, WR,
                                  Z, NZ, ABS | LUT, ABS, 14'd1, SEL | WE, 14'd0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("chk %-16s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("FAIL %-16s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic exec(input logic [3:0] op, input logic fc, input logic [13:0] exp);
        bus.opcode = op;
        bus.fcode  = fc;
        #1;
        check($sformatf("run_op%0h_f%0d", op, fc), 32'(strb), 32'(exp));
        check($sformatf("stall_op%0h", op), 32'(bus.pc_stall), 32'd0);
        exp_ret++;
        tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        bus.START  = 1'b0;
        bus.DONE   = 1'b0;
        bus.opcode = 4'h0;
        bus.fcode  = 1'b0;
        #3;
        check("rst_strobes", 32'(strb), 32'd0);
        check("rst_pc_stall", 32'(bus.pc_stall), 32'd1);
        check("rst_dp_start", 32'(bus.dp_start), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_retired", 32'(bus.retired), 32'd0);
        #10 reset_n = 1'b1;

        // START pulse: IDLE -> INIT (dp_start) -> RUN
        tick();
        bus.START = 1'b1;
        #1;
        check("idle_dp_start", 32'(bus.dp_start), 32'd0);
        tick();
        bus.START = 1'b0;
        #1;
        check("init_dp_start", 32'(bus.dp_start), 32'd1);
        check("init_strobes", 32'(strb), 32'd0);
        check("init_pc_stall", 32'(bus.pc_stall), 32'd1);
        tick();
        exec(4'h0, 1'b0, WE);
        check("run_dp_start", 32'(bus.dp_start), 32'd0);
        for (int i = 0; i < 15; i++) exec(tbl_op[i], tbl_fc[i], tbl_exp[i]);
        check("retired_16", 32'(bus.retired), PERF ? 32'd16 : 32'd0);

        // LW: two cycles, PC held in the first
        bus.opcode = 4'h8;
        #1;
        check("lw1_strobes", 32'(strb), 32'(RD));
        check("lw1_pc_stall", 32'(bus.pc_stall), 32'd1);
        tick();
        bus.opcode = 4'hF;
        #1;
        check("lw2_strobes", 32'(strb), 32'(RD | M2R | WE));
        check("lw2_pc_stall", 32'(bus.pc_stall), 32'd0);
        tick();
        check("retired_17", 32'(bus.retired), PERF ? 32'd17 : 32'd0);
        check("stall_1", 32'(bus.stall_cycles), PERF ? 32'd1 : 32'd0);

        // HALT instruction
        bus.opcode = 4'hF;
        bus.fcode  = 1'b1;
        #1;
        check("halt_op_strobes", 32'(strb), 32'd0);
        check("halt_op_pc_stall", 32'(bus.pc_stall), 32'd1);
        tick();
        bus.opcode = 4'h0;
        bus.fcode  = 1'b0;
        #1;
        check("halted", 32'(bus.halted), 32'd1);
        check("halted_strobes", 32'(strb), 32'd0);
        tick();
        check("halted_frozen", 32'(bus.retired), PERF ? 32'd17 : 32'd0);

        // Restart from HALT clears counters
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        #1;
        check("restart_dp_start", 32'(bus.dp_start), 32'd1);
        check("restart_halted", 32'(bus.halted), 32'd0);
        tick();
        check("restart_retired", 32'(bus.retired), 32'd0);
        bus.opcode = 4'h8;
        tick();
        bus.opcode = 4'h0;
        tick();
        check("fresh_lw_retired", 32'(bus.retired), PERF ? 32'd1 : 32'd0);
        check("fresh_lw_stall", 32'(bus.stall_cycles), PERF ? 32'd1 : 32'd0);

        // START and DONE together in LOAD2: START wins, write suppressed
        bus.opcode = 4'h8;
        tick();
        bus.START = 1'b1;
        bus.DONE  = 1'b1;
        #1;
        check("abort_we", 32'(bus.CTRL_reg_write_en), 32'd0);
        tick();
        bus.START = 1'b0;
        bus.DONE  = 1'b0;
        #1;
        check("abort_to_init", 32'(bus.dp_start), 32'd1);
        check("abort_halted", 32'(bus.halted), 32'd0);
        tick();

        // DONE in RUN: strobes forced off, then HALT
        bus.opcode = 4'h0;
        bus.DONE   = 1'b1;
        #1;
        check("done_strobes", 32'(strb), 32'd0);
        tick();
        bus.DONE = 1'b0;
        #1;
        check("done_halted", 32'(bus.halted), 32'd1);

        // Asynchronous reset in the middle of LOAD2
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        tick();
        bus.opcode = 4'h8;
        tick();
        #1;
        check("load2_we", 32'(bus.CTRL_reg_write_en), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_strobes", 32'(strb), 32'd0);
        check("arst_pc_stall", 32'(bus.pc_stall), 32'd1);
        check("arst_dp_start", 32'(bus.dp_start), 32'd0);
        check("arst_halted", 32'(bus.halted), 32'd0);
        check("arst_stall_cnt", 32'(bus.stall_cycles), 32'd0);
        tick();
        reset_n = 1'b1;

        // Long run: 300 ADDs; the counter saturates at all-ones when present
        tick();
        bus.START = 1'b1;
        tick();
        bus.START  = 1'b0;
        bus.opcode = 4'h0;
        tick();
        for (int i = 0; i < 300; i++) tick();
        check("retired_300", 32'(bus.retired), PERF ? 32'd255 : 32'd0);
        check("stall_300", 32'(bus.stall_cycles), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
